// File: rtl/tri_setup.sv
// Triangle setup: gathers six vertex bytes, derives three edge equations (A,B,C), hands them to the rasterizer.
// Optional back-face culling stage enabled by defining TRI_SETUP_BACKFACE_CULL_EN.
module tri_setup (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        tri_valid,
    input  logic        tri_ready,
    output logic [26:0] edge_a,
    output logic [26:0] edge_b,
    output logic [50:0] edge_c,
    output logic        culled
);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SETUP = 2'd1,
        ST_OUT   = 2'd2
`ifdef TRI_SETUP_BACKFACE_CULL_EN
        , ST_CULL = 2'd3
`endif
    } state_t;

    state_t            state, state_nxt;
    logic [2:0]        byte_cnt;
    logic [1:0]        edge_idx;
    logic [5:0][7:0]   vtx;
    logic [2:0][8:0]   a_q, b_q;
    logic [2:0][16:0]  c_q;
    logic [7:0]        xi, yi, xj, yj;
    logic [15:0]       p_ij, p_ji;
    logic [8:0]        a_new, b_new;
    logic [16:0]       c_new;
    logic              setup_last;

    assign setup_last = (edge_idx == 2'd2);

`ifdef TRI_SETUP_BACKFACE_CULL_EN
    logic [18:0] c_sum;
    logic        sum_nonpos;

    // Two guard bits: three 17-bit terms cannot overflow 19 bits.
    assign c_sum = {{2{c_q[0][16]}}, c_q[0]} + {{2{c_q[1][16]}}, c_q[1]} + {{2{c_q[2][16]}}, c_q[2]};
    assign sum_nonpos = c_sum[18] || (c_sum == 19'd0);
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= ST_LOAD;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD:  if (in_valid && (byte_cnt == 3'd5)) state_nxt = ST_SETUP;
            ST_SETUP: if (setup_last) begin
`ifdef TRI_SETUP_BACKFACE_CULL_EN
                state_nxt = ST_CULL;
`else
                state_nxt = ST_OUT;
`endif
            end
`ifdef TRI_SETUP_BACKFACE_CULL_EN
            ST_CULL:  state_nxt = sum_nonpos ? ST_LOAD : ST_OUT;
`endif
            ST_OUT:   if (tri_ready) state_nxt = ST_LOAD;
            default:  state_nxt = ST_LOAD;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_LOAD);
        tri_valid = (state == ST_OUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt <= 3'd0;
            edge_idx <= 2'd0;
        end else begin
            if (in_ready && in_valid)
                byte_cnt <= (byte_cnt == 3'd5) ? 3'd0 : byte_cnt + 3'd1;
            if (state == ST_SETUP)
                edge_idx <= setup_last ? 2'd0 : edge_idx + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                        vtx <= '0;
        else if (in_ready && in_valid)  vtx[byte_cnt] <= in_data;
    end

    // Edge i runs from vertex i to vertex (i+1) mod 3.
    always_comb begin
        xi = vtx[0]; yi = vtx[1]; xj = vtx[2]; yj = vtx[3];
        case (edge_idx)
            2'd1: begin xi = vtx[2]; yi = vtx[3]; xj = vtx[4]; yj = vtx[5]; end
            2'd2: begin xi = vtx[4]; yi = vtx[5]; xj = vtx[0]; yj = vtx[1]; end
            default: ;
        endcase
    end

    assign p_ij  = {8'd0, xi} * {8'd0, yj};
    assign p_ji  = {8'd0, xj} * {8'd0, yi};
    assign a_new = {1'b0, yi} - {1'b0, yj};
    assign b_new = {1'b0, xj} - {1'b0, xi};
    assign c_new = {1'b0, p_ij} - {1'b0, p_ji};

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
        end else if (state == ST_SETUP) begin
            a_q[edge_idx] <= a_new;
            b_q[edge_idx] <= b_new;
            c_q[edge_idx] <= c_new;
        end
    end

    assign edge_a = a_q;
    assign edge_b = b_q;
    assign edge_c = c_q;

`ifdef TRI_SETUP_BACKFACE_CULL_EN
    always_ff @(posedge clk) begin
        if (rst) culled <= 1'b0;
        else     culled <= (state == ST_CULL) && sum_nonpos;
    end
`else
    assign culled = 1'b0;
`endif

endmodule

// File: tb/tb_tri_setup.sv
// Directed bench for tri_setup: integer edge-equation model plus hand-computed literal pins.
module tb_tri_setup;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        tri_ready = 1'b0;
    logic        in_ready, tri_valid, culled;
    logic [26:0] edge_a, edge_b;
    logic [50:0] edge_c;

    int n_tests = 0;
    int n_fail  = 0;

    logic [26:0] exp_a = '0, exp_b = '0;
    logic [50:0] exp_c = '0;
    logic        exp_cull = 1'b0;

`ifdef TRI_SETUP_BACKFACE_CULL_EN
    localparam bit CULL_EN = 1'b1;
    localparam int LAT     = 4;
`else
    localparam bit CULL_EN = 1'b0;
    localparam int LAT     = 3;
`endif

    always #5 clk = ~clk;

    tri_setup dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .tri_valid(tri_valid), .tri_ready(tri_ready), .edge_a(edge_a), .edge_b(edge_b),
        .edge_c(edge_c), .culled(culled)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Edge equations straight from the geometry, in plain integers.
    task automatic set_model(input int b0, input int b1, input int b2, input int b3, input int b4, input int b5);
        int x[3];
        int y[3];
        int a, b, c, s, j;
        logic [31:0] t;
        x = '{b0, b2, b4};
        y = '{b1, b3, b5};
        s = 0;
        for (int i = 0; i < 3; i++) begin
            j = (i + 1) % 3;
            a = y[i] - y[j];
            b = x[j] - x[i];
            c = x[i] * y[j] - x[j] * y[i];
            s += c;
            t = a; exp_a[9*i +: 9]  = t[8:0];
            t = b; exp_b[9*i +: 9]  = t[8:0];
            t = c; exp_c[17*i +: 17] = t[16:0];
        end
        exp_cull = CULL_EN && (s <= 0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("cmp_ready_valid_excl", in_ready & tri_valid, 0);
            if (tri_valid) begin
                chk("cmp_edge_a", edge_a, exp_a);
                chk("cmp_edge_b", edge_b, exp_b);
                chk("cmp_edge_c", edge_c, exp_c);
                chk("cmp_valid_expected", tri_valid, !exp_cull);
            end
            if (culled) chk("cmp_culled_expected", culled, exp_cull);
        end
    end

    task automatic run_tri(input int b0, input int b1, input int b2, input int b3, input int b4, input int b5);
        int bb[6];
        int n;
        bb = '{b0, b1, b2, b3, b4, b5};
        set_model(b0, b1, b2, b3, b4, b5);
        for (int k = 0; k < 6; k++) begin
            chk("load_in_ready", in_ready, 1);
            in_valid = 1'b1;
            in_data  = 8'(bb[k]);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n = 0;
        while (n < 12 && !tri_valid && !culled) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_cull) begin
            chk("cull_latency", n, LAT);
            chk("cull_pulse", culled, 1);
            chk("cull_no_tv", tri_valid, 0);
            @(posedge clk); #1;
            chk("cull_one_cycle", culled, 0);
            chk("cull_back_to_load", in_ready, 1);
        end else begin
            chk("tv_latency", n, LAT);
            chk("tv_high", tri_valid, 1);
            chk("tv_no_culled", culled, 0);
        end
    endtask

    task automatic accept();
        tri_ready = 1'b1;
        @(posedge clk); #1;
        tri_ready = 1'b0;
        chk("hs_in_ready", in_ready, 1);
        chk("hs_tv_low", tri_valid, 0);
    endtask

    initial begin
        int s;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_tv", tri_valid, 0);
        chk("rst_culled", culled, 0);
        chk("rst_edge_a", edge_a, 0);
        chk("rst_edge_b", edge_b, 0);
        chk("rst_edge_c", edge_c, 0);
        rst = 1'b0;

        // Reference triangle, then held output with stray in_valid ignored.
        run_tri(10, 10, 50, 10, 10, 50);
        chk("lit_a_ref", edge_a, {9'h028, 9'h1D8, 9'h000});
        chk("lit_b_ref", edge_b, {9'h000, 9'h1D8, 9'h028});
        chk("lit_c_ref", edge_c, {17'h1FE70, 17'h00960, 17'h1FE70});
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hFF;
            @(posedge clk); #1;
            chk("hold_tv", tri_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_c", edge_c, {17'h1FE70, 17'h00960, 17'h1FE70});
        end
        in_valid = 1'b0;
        accept();

        // Extremes, with tri_ready already high before OUT.
        tri_ready = 1'b1;
        run_tri(0, 0, 255, 0, 0, 255);
        chk("lit_a_max", edge_a, {9'd255, 9'h101, 9'd0});
        chk("lit_b_max", edge_b, {9'd0, 9'h101, 9'd255});
        chk("lit_c_max", edge_c, {17'd0, 17'd65025, 17'd0});
        accept();

        // Clockwise triangle.
        run_tri(10, 10, 10, 50, 50, 10);
`ifndef TRI_SETUP_BACKFACE_CULL_EN
        s = $signed(edge_c[16:0]) + $signed(edge_c[33:17]) + $signed(edge_c[50:34]);
        chk("cw_c_sum", s, -1600);
`endif
        if (!exp_cull) accept();

        // Collinear (zero area).
        run_tri(0, 0, 10, 10, 20, 20);
        if (!exp_cull) accept();

        // Reset mid-load, with in_valid asserted in the reset cycle.
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = 8'(99 - 20 * k);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        in_data = 8'd200;
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        chk("rstload_in_ready", in_ready, 1);
        chk("rstload_edge_a", edge_a, 0);
        run_tri(30, 20, 200, 40, 100, 180);
        accept();

        // Reset while holding a triangle in OUT, tri_ready high in the same cycle.
        run_tri(10, 10, 50, 10, 10, 50);
        rst = 1'b1;
        tri_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tri_ready = 1'b0;
        chk("rstout_tv", tri_valid, 0);
        chk("rstout_in_ready", in_ready, 1);
        chk("rstout_edge_c", edge_c, 0);
        run_tri(5, 7, 200, 9, 60, 250);
        accept();

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, limit 200000 reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tri_setup.md
TRI_SETUP -- requirements
Module: tri_setup

Interface
REQ-001 SHALL have one clock, clk; reset is synchronous and active-high, rst; all state changes on rising clk.
REQ-002 clk  input  1  system clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 in_valid  input  1  vertex byte strobe.
REQ-005 in_data  input  8  vertex byte, unsigned; order x0,y0,x1,y1,x2,y2.
REQ-006 in_ready  output  1  byte accepted on a clk edge when in_valid&&in_ready.
REQ-007 tri_valid  output  1  edge coefficients valid toward rasterizer.
REQ-008 tri_ready  input  1  rasterizer accepts triangle on a clk edge when tri_valid&&tri_ready.
REQ-009 edge_a  output  27  three signed 9-bit A coefficients, edge i at bits [9i+8:9i].
REQ-010 edge_b  output  27  three signed 9-bit B coefficients, same packing.
REQ-011 edge_c  output  51  three signed 17-bit C coefficients, edge i at [17i+16:17i].
REQ-012 culled  output  1  one-cycle pulse when a triangle is dropped.

Function
REQ-013 SHALL implement states LOAD, SETUP, CULL, OUT; in_ready=1 only in LOAD; tri_valid=1 only in OUT.
REQ-014 LOAD: byte counter 0..5 increments per accepted byte; in_valid while not in LOAD is ignored.
REQ-015 On acceptance of byte 5, SHALL clear counter, enter SETUP with edge index 0.
REQ-016 SETUP: compute one edge per cycle, index 0,1,2; edge i runs vertex i -> vertex (i+1) mod 3.
REQ-017 Edge arithmetic: A=y_i-y_j, B=x_j-x_i, C=x_i*y_j-x_j*y_i; operands zero-extended to signed; no truncation (A,B fit 9 bits, C fits 17 bits).
REQ-018 After edge 2: enter CULL if BACKFACE_CULL_EN defined, else OUT.
REQ-019 Latency without cull: byte 5 accepted at edge k -> tri_valid high after edge k+3; with cull, after edge k+4.
REQ-020 OUT: edge_a/edge_b/edge_c and tri_valid SHALL hold stable until tri_ready sampled high; on handshake return to LOAD, in_ready high next cycle.
REQ-021 tri_ready high outside OUT SHALL have no effect.
REQ-022 edge_* outputs SHALL change only during SETUP; value outside OUT is don't-care for consumers but deterministic.

Reset
REQ-023 rst high at an edge SHALL force LOAD, byte counter 0, edge index 0, edge_a/edge_b/edge_c 0, culled 0, tri_valid 0, in_ready 1 next cycle.
REQ-024 Reset mid-LOAD discards partial vertices; mid-SETUP/OUT discards triangle without handshake; rst dominates in_valid/tri_ready same cycle.

Configuration
REQ-025 Macro TRI_SETUP_BACKFACE_CULL_EN.
REQ-026 Defined: CULL state computes 19-bit signed sum S=C0+C1+C2; S<=0 (clockwise or degenerate) -> culled pulses 1 for one cycle, return to LOAD, no tri_valid; S>0 -> OUT next cycle.
REQ-027 Undefined: no CULL state, no sum logic, culled tied 0, every triangle reaches OUT.

Verification
REQ-028 Bytes 10,10,50,10,10,50 -> A=(0,-40,40), B=(40,-40,0), C=(-400,2400,-400); tri_valid 3 cycles (4 with cull) after last byte.
REQ-029 Same triangle, tri_ready low 5 cycles after tri_valid -> outputs and tri_valid stable, in_ready 0 throughout; tri_ready high -> in_ready 1 next cycle.
REQ-030 Cull enabled, bytes 10,10,10,50,50,10 (S=-1600) -> culled single-cycle pulse, tri_valid never high; cull disabled -> tri_valid with C sum -1600.
REQ-031 Bytes 0,0,255,0,0,255 -> C=(0,65025,0), A=(0,-255,255), B=(255,-255,0) without overflow.
REQ-032 rst after 3 bytes, then full 6-byte triangle -> coefficients match the new triangle only.
REQ-033 Collinear 0,0,10,10,20,20 (S=0) -> culled when enabled; passed through when disabled.
